// File: rtl/seg_scan_disp_pkg.sv
// Shared constants for the scanned hex display: the segment encoding table and
// the leading-zero mask helper used by the output stage.
package disp_pkg;

  localparam int SEG_W      = 7;
  localparam int MAX_DIGITS = 16;
  localparam int LZ_DATA_W  = 4 * MAX_DIGITS;
  localparam int LZ_IDX_W   = $clog2(MAX_DIGITS);

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Active-high {g,f,e,d,c,b,a}; entry n shows hex digit n.
  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Bit i set means digit i is a leading zero (it and every higher nibble are 0).
  // Bit 0 is never set so a zero value still shows a single '0'.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [LZ_DATA_W-1:0] data);
    logic [MAX_DIGITS-1:0] mask;
    logic                  zero_run;
    mask     = '0;
    zero_run = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (data[4*i +: 4] == 4'h0);
      mask[i]  = zero_run;
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_scan_disp_if.sv
// Load port of the scanned display: one value plus per-digit decimal points.
// Handshake: a transfer happens at a clk edge where load_valid && load_ready;
// the master holds load_data/load_dp stable while load_valid is high and unaccepted.
interface seg_scan_disp_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DIGITS = 4
);
  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] load_data;
  logic [NUM_DIGITS-1:0] load_dp;

  modport master (
    output load_valid,
    output load_data,
    output load_dp,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_dp,
    output load_ready
  );
endinterface

// File: rtl/seg_scan_disp_dec.sv
// Combinational nibble to active-high 7-segment decoder.
module hex7seg_dec
  import disp_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg_scan_disp.sv
// Time-multiplexed hex display driver: one decoder scanned across NUM_DIGITS
// digits, with a pending/display double buffer swapped only at frame end.
module seg_scan_disp
  import disp_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  seg_scan_disp_if.slave   load,
  input  logic             blank_lz,
  input  logic             freeze,
  output logic [SEG_W-1:0] seg,
  output logic             dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int NIB_W = 4 * NUM_DIGITS;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // XOR masks: the inactive level of each output, also used to apply polarity.
  localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{ACTIVE_LOW_SEG}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW_AN}};
  localparam logic                  DP_OFF  = ACTIVE_LOW_SEG;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0] dig_idx_q, dig_idx_d;

  logic [NUM_DIGITS-1:0][3:0] disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0]      disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0][3:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]      pend_dp_q, pend_dp_d;
  logic                       pend_full_q, pend_full_d;
  logic                       ready_q;

  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic tick;
  logic frame_end;
  logic accept;
  logic transfer;

  logic [3:0]            cur_nibble;
  logic [SEG_W-1:0]      dec_seg;
  logic [SEG_W-1:0]      seg_act;
  logic [MAX_DIGITS-1:0] lz_full;
  logic                  blank_dig;

  // Scan timing, load handshake and double-buffer control.
  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    frame_end = tick && (dig_idx_q == IDX_LAST);
    accept    = load.load_valid && ready_q;
    transfer  = frame_end && pend_full_q && !freeze;

    div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);
    dig_idx_d   = dig_idx_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;

    if (tick) begin
      dig_idx_d = (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + IDX_W'(1);
    end

    // ready_q is low whenever pend_full_q is set, so these never both fire.
    if (accept) begin
      pend_data_d = NIB_W'(load.load_data);
      pend_dp_d   = load.load_dp;
      pend_full_d = 1'b1;
    end else if (transfer) begin
      disp_data_d = pend_data_q;
      disp_dp_d   = pend_dp_q;
      pend_full_d = 1'b0;
    end
  end

  assign cur_nibble = disp_data_q[dig_idx_q];

  hex7seg_dec u_dec (
    .nibble_i (cur_nibble),
    .seg_o    (dec_seg)
  );

  // Output stage: select, blank, then apply polarity just before the register.
  always_comb begin
    lz_full   = lz_mask(LZ_DATA_W'(disp_data_q));
    blank_dig = blank_lz && lz_full[LZ_IDX_W'(dig_idx_q)];
    seg_act   = blank_dig ? SEG_BLANK : dec_seg;

    seg_d = seg_act ^ SEG_OFF;
    dp_d  = disp_dp_q[dig_idx_q] ^ DP_OFF;
    an_d  = (NUM_DIGITS'(1) << dig_idx_q) ^ AN_OFF;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt_q   <= '0;
      dig_idx_q   <= '0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b0;
      seg_q       <= SEG_OFF;
      dp_q        <= DP_OFF;
      an_q        <= AN_OFF;
    end else begin
      div_cnt_q   <= div_cnt_d;
      dig_idx_q   <= dig_idx_d;
      disp_data_q <= disp_data_d;
      disp_dp_q   <= disp_dp_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_full_q <= pend_full_d;
      ready_q     <= !pend_full_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign load.load_ready = ready_q;
  assign seg             = seg_q;
  assign dp              = dp_q;
  assign an              = an_q;

endmodule

// File: tb/tb_seg_scan_disp.sv
// Bench for seg_scan_disp: directed scenarios plus random traffic, every cycle
// compared against a frame-level model built from cycle count arithmetic.
module tb_seg_scan_disp;

  localparam int ND = 4;
  localparam int DW = 16;
  localparam int CD = 4;
  localparam int FRAME = CD * ND;

  // Reference segment shapes, active-high {g,f,e,d,c,b,a}.
  localparam logic [6:0] REF_SEG [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          blank_lz = 1'b0;
  logic          freeze   = 1'b0;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] an;

  seg_scan_disp_if #(.DATA_WIDTH(DW), .NUM_DIGITS(ND)) load_if ();

  seg_scan_disp #(
    .DATA_WIDTH     (DW),
    .NUM_DIGITS     (ND),
    .CLK_DIV        (CD),
    .ACTIVE_LOW_SEG (1'b1),
    .ACTIVE_LOW_AN  (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load_if),
    .blank_lz (blank_lz),
    .freeze   (freeze),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  // Accepted-but-not-yet-shown loads, {dp, data}.
  logic [ND+DW-1:0] exp_q[$];
  int unsigned      cyc;
  logic [DW-1:0]    m_disp;
  logic [ND-1:0]    m_dp;
  logic             m_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: advance the model across the edge, then compare all outputs.
  task automatic step();
    int               slot;
    logic             fe;
    logic             acc;
    logic             xfer;
    logic [DW-1:0]    shifted;
    logic [6:0]       seg_hi;
    logic [ND-1:0]    e_an;
    logic [6:0]       e_seg;
    logic             e_dp;
    logic [ND+DW-1:0] ent;
    logic [ND-1:0]    one_hot;
    @(posedge clk);
    if (!rst) begin
      cyc     = 0;
      m_disp  = '0;
      m_dp    = '0;
      m_ready = 1'b0;
      exp_q.delete();
      e_an  = '1;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      slot    = int'((cyc / CD) % ND);
      fe      = ((cyc % FRAME) == FRAME - 1);
      shifted = m_disp >> (4 * slot);
      seg_hi  = (blank_lz && slot > 0 && shifted == '0) ? 7'h00 : REF_SEG[shifted[3:0]];
      one_hot = '0;
      one_hot[slot] = 1'b1;
      e_an  = ~one_hot;
      e_seg = ~seg_hi;
      e_dp  = ~m_dp[slot];

      acc  = load_if.load_valid && m_ready;
      xfer = fe && (exp_q.size() != 0) && !freeze;
      if (acc) exp_q.push_back({load_if.load_dp, load_if.load_data});
      if (xfer) begin
        ent    = exp_q.pop_front();
        m_disp = ent[DW-1:0];
        m_dp   = ent[ND+DW-1:DW];
      end
      m_ready = (exp_q.size() == 0);
      cyc++;
    end
    #1;
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("load_ready", 32'(load_if.load_ready), 32'(m_ready));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // ---------------- driver tasks ----------------
  task automatic offer(input logic [DW-1:0] d, input logic [ND-1:0] p);
    logic got;
    int   n;
    load_if.load_valid = 1'b1;
    load_if.load_data  = d;
    load_if.load_dp    = p;
    got = 1'b0;
    n   = 0;
    while (!got && n < 200) begin
      got = m_ready && rst;
      step();
      n++;
    end
    load_if.load_valid = 1'b0;
    check("offer_accepted", 32'(got), 32'd1);
  endtask

  task automatic random_traffic(input int n);
    logic take;
    for (int i = 0; i < n; i++) begin
      if (!load_if.load_valid && $urandom_range(0, 2) == 0) begin
        load_if.load_valid = 1'b1;
        load_if.load_data  = DW'($urandom) >> (4 * $urandom_range(0, 4));
        load_if.load_dp    = ND'($urandom);
      end
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 47) == 0) freeze = ~freeze;
      take = load_if.load_valid && m_ready;
      step();
      if (take) load_if.load_valid = 1'b0;
    end
    freeze = 1'b0;
    load_if.load_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    load_if.load_valid = 1'b0;
    load_if.load_data  = '0;
    load_if.load_dp    = '0;

    // Reset hold, then release.
    rst = 1'b0;
    run(3);
    rst = 1'b1;
    run(2);

    // Basic display with a decimal point on digit 2.
    offer(16'h12AB, 4'b0100);
    run(2 * FRAME + 3);

    // Back-to-back loads within one frame: second stalls until after frame_end.
    offer(16'h1111, 4'b0000);
    offer(16'h2222, 4'b0001);
    run(2 * FRAME + 5);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    offer(16'h0050, 4'b1000);
    run(2 * FRAME + 1);
    offer(16'h0000, 4'b0000);
    run(2 * FRAME + 2);
    blank_lz = 1'b0;

    // Freeze holds ABCD while 0001 waits in the pending buffer.
    offer(16'hABCD, 4'b0000);
    run(2 * FRAME);
    freeze = 1'b1;
    offer(16'h0001, 4'b0010);
    run(3 * FRAME);
    freeze = 1'b0;
    run(2 * FRAME + 3);

    // Reset mid-frame with the pending buffer full.
    freeze = 1'b1;
    offer(16'h5A5A, 4'b1111);
    run(5);
    rst = 1'b0;
    run(1);
    rst = 1'b1;
    freeze = 1'b0;
    run(3 * FRAME);

    // Random traffic with blanking and freeze toggling.
    random_traffic(600);
    run(2 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
